// File: rtl/mips_run_ctrl_pkg.sv
// rtl/mips_run_ctrl_pkg.sv - shared state encoding and parameter defaults for the run controller
package mips_run_ctrl_pkg;

  localparam int DIV_DEFAULT    = 25000000;
  localparam int DB_CNT_DEFAULT = 500000;
  localparam int DB_CNT_W       = 20;

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_BREAK = 2'd3
  } run_state_e;

  function automatic logic is_halted(run_state_e s);
    return (s == ST_HALT) || (s == ST_BREAK);
  endfunction

endpackage

// File: rtl/mips_run_ctrl_if.sv
// rtl/mips_run_ctrl_if.sv - board-side control and status bundle of the run controller
interface mips_run_ctrl_if;

  logic        run_sw;
  logic        step_btn;
  logic        bp_en;
  logic [31:0] bp_pc;
  logic [31:0] pc;
  logic        cpu_tick;
  logic [1:0]  state;
  logic        halted;
  logic [15:0] tick_cnt;

  modport master (
    output run_sw, step_btn, bp_en, bp_pc, pc,
    input  cpu_tick, state, halted, tick_cnt
  );

  modport slave (
    input  run_sw, step_btn, bp_en, bp_pc, pc,
    output cpu_tick, state, halted, tick_cnt
  );

endinterface

// File: rtl/mips_run_ctrl_btn_debounce.sv
// rtl/mips_run_ctrl_btn_debounce.sv - step button synchroniser, debouncer and rising-edge pulse
module btn_debounce
  import mips_run_ctrl_pkg::*;
#(
  parameter int DB_CNT = DB_CNT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic step_req_o
);

  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DB_CNT - 1);

  logic                sync1_q, sync2_q;
  logic                level_q, level_d;
  logic                level_prev_q;
  logic [DB_CNT_W-1:0] cnt_q, cnt_d;

  // The level only moves after DB_CNT back-to-back disagreeing samples.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn_i;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      cnt_q        <= cnt_d;
    end
  end

  assign step_req_o = level_q & ~level_prev_q;

endmodule

// File: rtl/mips_run_ctrl.sv
// rtl/mips_run_ctrl.sv - HALT/RUN/STEP/BREAK controller issuing CPU clock-enable ticks
module mips_run_ctrl
  import mips_run_ctrl_pkg::*;
#(
  parameter int DIV    = DIV_DEFAULT,
  parameter int DB_CNT = DB_CNT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  mips_run_ctrl_if.slave  bus
);

  localparam logic [31:0] DIV_LAST = 32'(DIV - 1);

  logic        step_req;
  logic        bp_hit;
  run_state_e  state_q, state_d;
  logic [31:0] div_q, div_d, div_inc;
  logic        tick_q, tick_d;
  logic [15:0] tick_cnt_q, tick_cnt_d;

  btn_debounce #(.DB_CNT(DB_CNT)) u_btn_debounce (
    .clk        (clk),
    .rst        (rst),
    .btn_i      (bus.step_btn),
    .step_req_o (step_req)
  );

  assign bp_hit = bus.bp_en && (bus.pc == bus.bp_pc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_HALT;
      div_q      <= '0;
      tick_q     <= 1'b0;
      tick_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      tick_q     <= tick_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  // The tick is registered alongside the divider, so the breakpoint compare
  // uses pc one cycle ahead; pc only moves on a tick, so it is the same value.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    div_inc = (div_q == DIV_LAST) ? 32'd0 : div_q + 32'd1;
    unique case (state_q)
      ST_HALT: begin
        if (bus.run_sw) begin
          state_d = ST_RUN;
          div_d   = '0;
        end else if (step_req) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        if (!bus.run_sw) begin
          state_d = ST_HALT;
          div_d   = '0;
        end else if ((div_inc == DIV_LAST) && bp_hit) begin
          state_d = ST_BREAK;
          div_d   = '0;
        end else begin
          div_d = div_inc;
        end
      end
      ST_STEP: begin
        state_d = ST_HALT;
      end
      ST_BREAK: begin
        if (!bus.run_sw) begin
          state_d = ST_HALT;
        end else if (step_req) begin
          state_d = ST_STEP;
        end
      end
      default: state_d = ST_HALT;
    endcase
  end

  always_comb begin
    tick_d     = (state_d == ST_STEP) || ((state_d == ST_RUN) && (div_d == DIV_LAST));
    tick_cnt_d = tick_cnt_q + {15'd0, tick_d};
  end

  assign bus.cpu_tick = tick_q;
  assign bus.state    = state_q;
  assign bus.halted   = is_halted(state_q);
  assign bus.tick_cnt = tick_cnt_q;

endmodule
